// File: rtl/pht_gshare.sv
// Pattern history table of saturating direction counters with a speculative
// global history register. Indexing is bimodal (PC only) or gshare (PC XOR
// history). The read index and the pre-shift history are exported so the
// pipeline can hand them back when the branch resolves.
module pht_gshare #(
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned GHR_WIDTH   = 10,
  parameter bit          GSHARE_EN   = 1'b1,
  parameter int unsigned PC_LSB      = 2,
  parameter int unsigned CTR_INIT    = 2**(CTR_WIDTH-1)-1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [31:0]            rd_pc_i,
  input  logic                   rd_valid_i,
  output logic                   br_prediction_o,
  output logic                   br_strong_o,
  output logic [INDEX_WIDTH-1:0] rd_index_o,
  output logic [GHR_WIDTH-1:0]   rd_ghr_o,
  input  logic                   update_en_i,
  input  logic [INDEX_WIDTH-1:0] update_index_i,
  input  logic                   update_taken_i,
  input  logic                   mispredict_i,
  input  logic [GHR_WIDTH-1:0]   update_ghr_i
);

  localparam int                   DEPTH   = 2**INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_RST = CTR_WIDTH'(CTR_INIT);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};

  logic [CTR_WIDTH-1:0]   ctr_q [DEPTH];
  logic [GHR_WIDTH-1:0]   ghr_q;
  logic [GHR_WIDTH-1:0]   ghr_d;
  logic [INDEX_WIDTH-1:0] pc_idx;
  logic [INDEX_WIDTH-1:0] rd_idx;
  logic [CTR_WIDTH-1:0]   rd_ctr;
  logic [CTR_WIDTH-1:0]   upd_ctr;
  logic [CTR_WIDTH-1:0]   upd_ctr_next;
  logic [GHR_WIDTH-1:0]   ghr_spec;
  logic [GHR_WIDTH-1:0]   ghr_fix;
  logic                   spec_msb;
  logic                   fix_msb;
  logic                   unused_bits;

  // Shifting left by one drops the oldest history bit; the MSB that falls off
  // is captured separately so the shifted value fits the register exactly.
  assign {spec_msb, ghr_spec} = {ghr_q, br_prediction_o};
  assign {fix_msb, ghr_fix}   = {update_ghr_i, update_taken_i};

  // PC bits outside the index window and the shifted-out history bits are
  // intentionally ignored.
  assign unused_bits = ^{rd_pc_i, spec_msb, fix_msb};

  // Read index and prediction lookup; purely combinational, no write bypass.
  always_comb begin
    pc_idx = rd_pc_i[PC_LSB +: INDEX_WIDTH];
    if (GSHARE_EN) begin
      rd_idx = pc_idx ^ INDEX_WIDTH'(ghr_q);
    end else begin
      rd_idx = pc_idx;
    end
    rd_ctr          = ctr_q[rd_idx];
    br_prediction_o = rd_ctr[CTR_WIDTH-1];
    br_strong_o     = (rd_ctr == CTR_MAX) || (rd_ctr == '0);
    rd_index_o      = rd_idx;
    rd_ghr_o        = ghr_q;
  end

  // Saturating increment/decrement of the counter being resolved. A 1-bit
  // counter degenerates to simply tracking the last outcome.
  always_comb begin
    upd_ctr      = ctr_q[update_index_i];
    upd_ctr_next = upd_ctr;
    if (update_taken_i) begin
      if (upd_ctr != CTR_MAX) begin
        upd_ctr_next = upd_ctr + CTR_WIDTH'(1);
      end
    end else begin
      if (upd_ctr != '0) begin
        upd_ctr_next = upd_ctr - CTR_WIDTH'(1);
      end
    end
  end

  // History next-state: misprediction repair beats the wrong-path speculative
  // shift; a correctly predicted resolve leaves the history alone.
  always_comb begin
    ghr_d = ghr_q;
    if (update_en_i && mispredict_i) begin
      ghr_d = ghr_fix;
    end else if (rd_valid_i) begin
      ghr_d = ghr_spec;
    end
  end

  // Counter table as a flop array so the whole table clears on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= CTR_RST;
      end
    end else if (update_en_i) begin
      ctr_q[update_index_i] <= upd_ctr_next;
    end
  end

  // Global history register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

endmodule

// File: doc/pht_gshare.md
Name: pht_gshare

Overview:
Parametrised pattern history table of N-bit saturating counters, the successor to the fixed 2-bit bimodal PHT. It supports bimodal or gshare indexing, selected by parameter. It holds an internal speculative global history register (GHR) with misprediction recovery, and exports the read index and GHR snapshot so the pipeline can return them at resolve time. It sits in the fetch stage, and its update port is driven from execute.

Parameters:
INDEX_WIDTH, 10, log2 of table depth; the table has 2**INDEX_WIDTH entries.
CTR_WIDTH, 2, counter width in bits; legal range 1..4.
GHR_WIDTH, 10, global history length; legal range 1..INDEX_WIDTH.
GSHARE_EN, 1, 1 selects gshare indexing (PC XOR GHR), 0 selects bimodal indexing (PC only; the GHR still runs).
PC_LSB, 2, first PC bit used for indexing.
CTR_INIT, 2**(CTR_WIDTH-1)-1, counter reset value (weakly not-taken).

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous active-low reset.
rd_pc_i  in  32  fetch PC to predict.
rd_valid_i  in  1  fetch slot holds a conditional branch; speculatively shifts the GHR.
br_prediction_o  out  1  predicted direction (MSB of the indexed counter).
br_strong_o  out  1  indexed counter is saturated, either all-ones or all-zeros.
rd_index_o  out  INDEX_WIDTH  index used for this read; carried down the pipe.
rd_ghr_o  out  GHR_WIDTH  GHR value before this read's shift; carried down the pipe.
update_en_i  in  1  a branch resolved this cycle.
update_index_i  in  INDEX_WIDTH  rd_index_o value captured at prediction time.
update_taken_i  in  1  actual branch outcome.
mispredict_i  in  1  resolved branch was mispredicted; repairs the GHR. Qualified by update_en_i.
update_ghr_i  in  GHR_WIDTH  rd_ghr_o value captured at prediction time.

Behaviour:
- Reset (rst_ni low, asynchronous): every counter is set to CTR_INIT and the GHR is set to 0. After reset, outputs settle to br_prediction_o = CTR_INIT[CTR_WIDTH-1], br_strong_o = (CTR_INIT==0), rd_ghr_o = 0. Reset asserted mid-operation discards all pending state immediately.
- Index computation:
  - pc_idx = rd_pc_i[PC_LSB +: INDEX_WIDTH].
  - GSHARE_EN=1: index = pc_idx XOR zero-extended GHR, with the GHR aligned to the LSBs.
  - GSHARE_EN=0: index = pc_idx.
- Read path:
  - Combinational, zero latency.
  - br_prediction_o, br_strong_o, rd_index_o and rd_ghr_o depend only on the current rd_pc_i and the registered GHR/table.
  - There is no write-to-read bypass: a same-cycle update to the read index is visible on the next cycle.
- Counter update, on the clock edge when update_en_i=1:
  - Taken: counter increments, saturating at 2**CTR_WIDTH-1.
  - Not taken: counter decrements, saturating at 0.
  - Only entry update_index_i changes.
  - With CTR_WIDTH=1 the counter simply becomes update_taken_i.
- GHR update, at most one action per edge, in priority order:
  1. update_en_i & mispredict_i: GHR <= {update_ghr_i[GHR_WIDTH-2:0], update_taken_i}. For GHR_WIDTH=1, GHR <= update_taken_i. The rd_valid_i shift in the same cycle is dropped, because the fetch is on the wrong path.
  2. Else if rd_valid_i: GHR <= {GHR[GHR_WIDTH-2:0], br_prediction_o}.
  3. Else: GHR holds.
- A correctly predicted update (update_en_i=1, mispredict_i=0) never modifies the GHR.
- Simultaneous update and read of the same index: the read returns the pre-update value, and the counter update still commits.
- Counter index arithmetic wraps modulo 2**INDEX_WIDTH naturally. There are no out-of-range indices.
- Implementation: flop array with asynchronous reset, not SRAM. The for-loop reset is acceptable up to INDEX_WIDTH=12.

Test Plan:
1. Reset with CTR_WIDTH=2 and any rd_pc_i → br_prediction_o=0, br_strong_o=0 (counter=01), rd_ghr_o=0.
2. Saturation, GSHARE_EN=0, PC=0x100 (index 0x040):
   - Three taken updates to 0x040 → prediction goes 0,1,1 and br_strong_o=1 after the third.
   - A fourth taken update → counter stays 11.
   - Four not-taken updates → counter reaches 00, br_strong_o=1.
3. Speculative history, GSHARE_EN=1, PC=0x100: five rd_valid_i cycles with prediction 0 → GHR stays 0 and rd_index_o=0x040.
   - Preload index 0x040 to 11, then one rd_valid_i cycle → GHR=0x001.
   - Next read of PC=0x100 → rd_index_o=0x041.
4. Recovery:
   - With GHR=0x2AB, assert update_en_i=1, mispredict_i=1, update_ghr_i=0x155, update_taken_i=1 together with rd_valid_i=1 → next GHR=0x2AB (0x155<<1 | 1, truncated to 10 bits), with no speculative shift.
5. Same-index collision: read index 0x010 while updating 0x010 taken from counter 01 → this cycle prediction=0; next cycle prediction=1.
6. Asynchronous reset mid-stream: drop rst_ni between clock edges after counters have been trained → outputs return to reset values before the next edge; all entries read CTR_INIT afterwards.
